store_narrow_unit: RTL and testbench
====================================

# store_narrow_unit

Store-side data narrowing unit for the single-cycle/pipelined MIPS datapath: the write-direction counterpart of the load path's sign/zero extension. Accepts a 32-bit register value with an access size (byte/halfword/word) and a byte address, and commits it to a word-wide data memory. Sub-word stores use a read-modify-write sequence. Sits between the EX/MEM stage and the data memory port; stalls the pipeline through a valid/ready handshake.

## Interface
- ADDR_WIDTH, 32, byte-address width; memory is word-addressed by the upper ADDR_WIDTH-2 bits.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- req_valid_i  input  1  store request present.
- req_ready_o  output  1  unit can accept a request this cycle.
- addr_i  input  ADDR_WIDTH  byte address, sampled on accept.
- data_i  input  32  store data; only low byte/halfword used for sub-word sizes; sampled on accept.
- size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- mem_addr_o  output  ADDR_WIDTH  word-aligned address, low two bits always 0.
- mem_rd_o  output  1  memory read strobe; data returns on mem_rdata_i exactly one cycle later.
- mem_rdata_i  input  32  memory read data.
- mem_wr_o  output  1  memory write strobe; full 32-bit word written.
- mem_wdata_o  output  32  word to write.
- done_o  output  1  one-cycle pulse: request completed (written or rejected).
- err_o  output  1  one-cycle pulse with done_o: request rejected, no memory access.

## Operation
- Accept: req_valid_i && req_ready_o at a rising edge; addr, data, size latched. req_ready_o=1 only in IDLE.
- States: IDLE, READ, MERGE, WRITE, ERR.
- IDLE → ERR if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
- IDLE → WRITE if legal word; merged word register ← data_i.
- IDLE → READ if legal byte/halfword.
- READ: mem_rd_o=1, mem_addr_o={addr[31:2],00}; → MERGE.
- MERGE: capture mem_rdata_i, replace one lane, hold in merged register; → WRITE.
- WRITE: mem_wr_o=1, mem_addr_o={addr[31:2],00}, mem_wdata_o=merged; done_o=1; → IDLE.
- ERR: done_o=1, err_o=1; no mem strobes; → IDLE.
- Lane rule (little-endian): byte lane k=addr[1:0] gets data[7:0] in bits [8k+7:8k]; halfword at addr[1]=0 → bits [15:0], addr[1]=1 → bits [31:16], from data[15:0]. All other bits come unchanged from mem_rdata_i. Upper bits of data_i are ignored, never sign-tested.
- Outside READ/WRITE: mem_addr_o=0, mem_wdata_o=0; mem_rd_o and mem_wr_o are never both 1.

## Timing
- Reset: while rst_i=0 at an edge, state←IDLE and merged←0. All outputs are 0 during any cycle in which rst_i=0, including req_ready_o. req_ready_o is 1 in the first cycle with rst_i=1.
- Word store accepted at edge T: WRITE and done_o in cycle T..T+1, so latency is 1 cycle. Next accept is possible at edge T+2.
- Sub-word store accepted at edge T: READ in cycle after T, MERGE the next, then WRITE/done_o. Latency is 3 cycles. Next accept is possible at edge T+4.
- Rejected request: ERR the cycle after accept, so latency is 1.
- Requests presented outside IDLE are not accepted. The requester holds valid and fields until ready.
- Reset asserted in READ/MERGE/WRITE aborts: no further mem_wr_o and no done_o for that request. A write strobe already issued is not retracted.
- Back-to-back requests to the same word are correct because each write completes before the next read.

## Test plan
- Word store: addr 0x10, data 0xDEADBEEF, size 10 → next cycle mem_wr_o=1, mem_addr_o=0x10, mem_wdata_o=0xDEADBEEF, done_o=1, err_o=0, mem_rd_o never 1.
- Byte store: addr 0x13, data 0xFFFFFFAB, size 00, memory word 0x11223344 → read at 0x10, then write 0xAB223344 to 0x10 three cycles after accept.
- Halfword store: addr 0x22, data 0x1234CAFE, size 01, memory 0x55667788 → write 0xCAFE7788 to 0x20, then 0x5566CAFE for addr 0x20.
- Illegal requests: halfword addr 0x21, word addr 0x26, or size 11 → next cycle done_o=1, err_o=1, no mem_rd_o/mem_wr_o, ready=1 the cycle after.
- Reset mid-operation: byte store accepted, rst_i=0 during MERGE → mem_wr_o stays 0, done_o stays 0, all outputs 0; ready=1 first cycle after release.
- Back-to-back: valid held with byte stores 0x44@0x30 then 0x55@0x31, memory initially 0 → second read returns 0x00000044, final write 0x00005544. Second accept occurs exactly one cycle after the first done_o.

Source files
------------

// File: rtl/store_narrow_unit.sv
// -----------------------------------------------------------------------------
// store_narrow_unit
// Store-side narrowing for the MIPS datapath. A word store is written straight
// to memory. A byte or halfword store reads the containing word, replaces one
// lane and writes the word back. Misaligned and illegal-size requests are
// rejected without any memory access.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active low; forces every output to 0
//   req_valid_i  store request present
//   req_ready_o  unit idle and able to accept
//   addr_i       byte address (sampled on accept)
//   data_i       store data, low byte/halfword for sub-word sizes
//   size_i       00 byte, 01 halfword, 10 word, 11 illegal
//   mem_addr_o   word-aligned memory address (0 outside READ/WRITE)
//   mem_rd_o     read strobe; data arrives on mem_rdata_i one cycle later
//   mem_rdata_i  memory read data
//   mem_wr_o     full-word write strobe
//   mem_wdata_o  word to write (0 outside WRITE)
//   done_o       one-cycle completion pulse (written or rejected)
//   err_o        one-cycle pulse with done_o for a rejected request
// -----------------------------------------------------------------------------
module store_narrow_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           data_i,
    input  logic [1:0]            size_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  mem_wr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned HALF_WIDTH = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [HALF_WIDTH-1:0]   data_q, data_d;
    logic                    is_half_q, is_half_d;
    logic [31:0]             merged_q, merged_d;

    logic                    accept;
    logic                    illegal;
    logic [31:0]             lane_word;
    logic [ADDR_WIDTH-1:0]   word_addr;

    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // Alignment/size legality of the presented request
    always_comb begin
        illegal = 1'b0;
        case (size_i)
            SIZE_BYTE: illegal = 1'b0;
            SIZE_HALF: illegal = addr_i[0];
            SIZE_WORD: illegal = (addr_i[1:0] != 2'b00);
            default:   illegal = 1'b1;
        endcase
    end

    // Replace one little-endian lane of the read word; other bits pass through
    always_comb begin
        lane_word = mem_rdata_i;
        if (is_half_q) begin
            if (addr_q[1]) begin
                lane_word[31:16] = data_q;
            end else begin
                lane_word[15:0]  = data_q;
            end
        end else begin
            case (addr_q[1:0])
                2'b00:   lane_word[7:0]   = data_q[7:0];
                2'b01:   lane_word[15:8]  = data_q[7:0];
                2'b10:   lane_word[23:16] = data_q[7:0];
                default: lane_word[31:24] = data_q[7:0];
            endcase
        end
    end

    // State register and latched request fields
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            is_half_q <= 1'b0;
            merged_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            is_half_q <= is_half_d;
            merged_q  <= merged_d;
        end
    end

    // Next-state and output decode; outputs forced low while reset is held
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        is_half_d   = is_half_q;
        merged_d    = merged_q;
        accept      = 1'b0;
        req_ready_o = 1'b0;
        mem_addr_o  = '0;
        mem_rd_o    = 1'b0;
        mem_wr_o    = 1'b0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        err_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                accept      = req_valid_i && rst_i;
                if (accept) begin
                    addr_d    = addr_i;
                    data_d    = data_i[HALF_WIDTH-1:0];
                    is_half_d = (size_i == SIZE_HALF);
                    if (illegal) begin
                        state_d = S_ERR;
                    end else if (size_i == SIZE_WORD) begin
                        merged_d = data_i;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = word_addr;
                state_d    = S_MERGE;
            end
            S_MERGE: begin
                merged_d = lane_word;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_o    = 1'b1;
                mem_addr_o  = word_addr;
                mem_wdata_o = merged_q;
                done_o      = 1'b1;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                done_o  = 1'b1;
                err_o   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!rst_i) begin
            req_ready_o = 1'b0;
            mem_addr_o  = '0;
            mem_rd_o    = 1'b0;
            mem_wr_o    = 1'b0;
            mem_wdata_o = '0;
            done_o      = 1'b0;
            err_o       = 1'b0;
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// -----------------------------------------------------------------------------
// Testbench for store_narrow_unit: directed stores against a small word memory,
// expected values written out by hand. Status vector order is
// {req_ready, mem_rd, mem_wr, done, err}.
// -----------------------------------------------------------------------------
module tb_store_narrow_unit;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  size = '0;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [4:0] st;
    assign st = {req_ready, mem_rd, mem_wr, done, err};

    store_narrow_unit #(.ADDR_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .addr_i      (addr),
        .data_i      (data),
        .size_i      (size),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_rdata_i (mem_rdata),
        .mem_wr_o    (mem_wr),
        .mem_wdata_o (mem_wdata),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, full-word writes, preload port
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
        if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] v);
        pl_idx  = idx;
        pl_data = v;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        addr      = a;
        data      = d;
        size      = s;
        req_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        issue(32'h10, 32'h1, 2'b10);
        tick();
        tick();
        tests_run++;
        if (st !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_status got %b exp %b", st, 5'b00000);
        end
        tests_run++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_bus got addr %h wdata %h exp 0 0", mem_addr, mem_wdata);
        end
        req_valid = 1'b0;
        rst_i     = 1'b1;
        #1;
        tests_run++;
        if (st !== 5'b10000) begin
            tests_failed++;
            $display("FAIL reset_release_ready got %b exp %b", st, 5'b10000);
        end
        tick();
    endtask

    task automatic test_word();
        issue(32'h10, 32'hDEADBEEF, 2'b10);
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (st !== 5'b00110) begin
            tests_failed++;
            $display("FAIL word_write_status got %b exp %b", st, 5'b00110);
        end
        tests_run++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_write_bus got %h/%h exp 00000010/deadbeef", mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (st !== 5'b10000) begin
            tests_failed++;
            $display("FAIL word_idle_status got %b exp %b", st, 5'b10000);
        end
        tests_run++;
        if (mem[4] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_mem got %h exp deadbeef", mem[4]);
        end
    endtask

    task automatic test_byte();
        preload(6'd4, 32'h11223344);
        issue(32'h13, 32'hFFFFFFAB, 2'b00);
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (st !== 5'b01000 || mem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL byte_read got %b @%h exp 01000 @00000010", st, mem_addr);
        end
        tick();
        tests_run++;
        if (st !== 5'b00000 || mem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL byte_merge got %b @%h exp 00000 @00000000", st, mem_addr);
        end
        tick();
        tests_run++;
        if (st !== 5'b00110 || mem_addr !== 32'h10 || mem_wdata !== 32'hAB223344) begin
            tests_failed++;
            $display("FAIL byte_write got %b @%h %h exp 00110 @00000010 ab223344", st, mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (st !== 5'b10000) begin
            tests_failed++;
            $display("FAIL byte_idle got %b exp %b", st, 5'b10000);
        end
    endtask

    task automatic test_half();
        logic [31:0] a_tab [2];
        logic [31:0] w_tab [2];
        a_tab[0] = 32'h22; w_tab[0] = 32'hCAFE7788;
        a_tab[1] = 32'h20; w_tab[1] = 32'h5566CAFE;
        for (int i = 0; i < 2; i++) begin
            preload(6'd8, 32'h55667788);
            issue(a_tab[i], 32'h1234CAFE, 2'b01);
            tick();
            req_valid = 1'b0;
            tests_run++;
            if (st !== 5'b01000 || mem_addr !== 32'h20) begin
                tests_failed++;
                $display("FAIL half_read[%0d] got %b @%h exp 01000 @00000020", i, st, mem_addr);
            end
            tick();
            tick();
            tests_run++;
            if (st !== 5'b00110 || mem_addr !== 32'h20 || mem_wdata !== w_tab[i]) begin
                tests_failed++;
                $display("FAIL half_write[%0d] got %b @%h %h exp 00110 @00000020 %h",
                         i, st, mem_addr, mem_wdata, w_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        logic [31:0] a_tab [3];
        logic [1:0]  s_tab [3];
        a_tab[0] = 32'h21; s_tab[0] = 2'b01;
        a_tab[1] = 32'h26; s_tab[1] = 2'b10;
        a_tab[2] = 32'h24; s_tab[2] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            issue(a_tab[i], 32'h0BADF00D, s_tab[i]);
            tick();
            req_valid = 1'b0;
            tests_run++;
            if (st !== 5'b00011 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL illegal_err[%0d] got %b @%h %h exp 00011 @0 0", i, st, mem_addr, mem_wdata);
            end
            tick();
            tests_run++;
            if (st !== 5'b10000) begin
                tests_failed++;
                $display("FAIL illegal_ready[%0d] got %b exp %b", i, st, 5'b10000);
            end
        end
    endtask

    task automatic test_reset_abort();
        preload(6'd4, 32'h99999999);
        issue(32'h13, 32'h000000AB, 2'b00);
        tick();
        req_valid = 1'b0;
        tick();
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (st !== 5'b00000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_in_reset got %b @%h %h exp 00000 @0 0", st, mem_addr, mem_wdata);
        end
        tick();
        tests_run++;
        if (st !== 5'b00000) begin
            tests_failed++;
            $display("FAIL abort_held got %b exp %b", st, 5'b00000);
        end
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (st !== 5'b10000) begin
            tests_failed++;
            $display("FAIL abort_release got %b exp %b", st, 5'b10000);
        end
        tick();
        tests_run++;
        if (st !== 5'b10000 || mem[4] !== 32'h99999999) begin
            tests_failed++;
            $display("FAIL abort_no_write got %b mem %h exp 10000 mem 99999999", st, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        preload(6'd12, 32'h00000000);
        issue(32'h30, 32'h00000044, 2'b00);
        tick();
        issue(32'h31, 32'h00000055, 2'b00);
        tests_run++;
        if (st !== 5'b01000 || mem_addr !== 32'h30) begin
            tests_failed++;
            $display("FAIL b2b_read1 got %b @%h exp 01000 @00000030", st, mem_addr);
        end
        tick();
        tick();
        tests_run++;
        if (st !== 5'b00110 || mem_wdata !== 32'h00000044) begin
            tests_failed++;
            $display("FAIL b2b_write1 got %b %h exp 00110 00000044", st, mem_wdata);
        end
        tick();
        tests_run++;
        if (st !== 5'b10000) begin
            tests_failed++;
            $display("FAIL b2b_ready got %b exp %b", st, 5'b10000);
        end
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (st !== 5'b01000 || mem_addr !== 32'h30) begin
            tests_failed++;
            $display("FAIL b2b_read2 got %b @%h exp 01000 @00000030", st, mem_addr);
        end
        tick();
        tests_run++;
        if (mem_rdata !== 32'h00000044) begin
            tests_failed++;
            $display("FAIL b2b_rdata got %h exp 00000044", mem_rdata);
        end
        tick();
        tests_run++;
        if (st !== 5'b00110 || mem_addr !== 32'h30 || mem_wdata !== 32'h00005544) begin
            tests_failed++;
            $display("FAIL b2b_write2 got %b @%h %h exp 00110 @00000030 00005544", st, mem_addr, mem_wdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
